pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the stall and flush inputs of PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Resolves load-use hazards, taken branches/jumps, multi-cycle mul/div occupancy of EX, and data-memory wait states. Flushed pipeline registers load the NOP/default-control bubble; stalled ones hold.

---
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: load-use, branch/jump, mul/div and dmem wait.
// Optional build macro HAZ_PERF_EN adds the perf_stall_cyc / perf_flush_cnt counters.
//
// state    | meaning
// RUN      | normal issue; branch, jump and load-use hazards are resolved here
// MD_BUSY  | mul/div occupies EX; md_cnt counts down the remaining freeze cycles
// MEM_WAIT | data memory stalled the pipe; md_pend remembers an interrupted mul/div
module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_regread1,
  input  logic       ID_regread2,
  input  logic       ID_jump,
  input  logic       EX_memread,
  input  logic [4:0] EX_wraddr,
  input  logic       EX_branch_taken,
  input  logic       EX_md_start,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_mem_stall,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       md_done
`ifdef HAZ_PERF_EN
  ,
  output logic [31:0] perf_stall_cyc,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d, eff_state;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             md_pend_q, md_pend_d;

  logic mem_wait;
  logic load_use;
  logic rs_hit, rt_hit;

  logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_stall_c, id_ex_flush_c;
  logic ex_mem_stall_c, ex_mem_flush_c, mem_wb_flush_c, md_done_c;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign rs_hit   = ID_regread1 & (ID_rs == EX_wraddr);
  assign rt_hit   = ID_regread2 & (ID_rt == EX_wraddr);
  assign load_use = EX_memread & (EX_wraddr != 5'd0) & (rs_hit | rt_hit);

  // Leaving MEM_WAIT, this cycle already behaves as the state being resumed.
  always_comb begin
    eff_state = state_q;
    if (state_q == MEM_WAIT) begin
      eff_state = md_pend_q ? MD_BUSY : RUN;
    end
  end

  always_comb begin
    state_d        = state_q;
    md_cnt_d       = md_cnt_q;
    md_pend_d      = md_pend_q;
    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    ex_mem_flush_c = 1'b0;
    mem_wb_flush_c = 1'b0;
    md_done_c      = 1'b0;

    if (mem_wait) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
      state_d        = MEM_WAIT;
      if (state_q == MD_BUSY) begin
        md_pend_d = 1'b1;
      end
    end else begin
      md_pend_d = 1'b0;
      case (eff_state)
        MD_BUSY: begin
          if (md_cnt_q != '0) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            md_cnt_d       = md_cnt_q - 1'b1;
            state_d        = MD_BUSY;
          end else begin
            md_done_c = 1'b1;
            state_d   = RUN;
          end
        end
        default: begin
          state_d = RUN;
          if (EX_md_start) begin
            pc_stall_c     = 1'b1;
            if_id_stall_c  = 1'b1;
            id_ex_stall_c  = 1'b1;
            ex_mem_flush_c = 1'b1;
            md_cnt_d       = CNT_W'(MD_LAT - 1);
            state_d        = MD_BUSY;
          end else if (EX_branch_taken) begin
            if_id_flush_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end else if (ID_jump) begin
            if_id_flush_c = 1'b1;
          end else if (load_use) begin
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            id_ex_flush_c = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      md_cnt_q  <= '0;
      md_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      md_cnt_q  <= md_cnt_d;
      md_pend_q <= md_pend_d;
    end
  end

  // Outputs are held low for the whole time reset is asserted.
  assign pc_stall     = rst_n & pc_stall_c;
  assign if_id_stall  = rst_n & if_id_stall_c;
  assign if_id_flush  = rst_n & if_id_flush_c;
  assign id_ex_stall  = rst_n & id_ex_stall_c;
  assign id_ex_flush  = rst_n & id_ex_flush_c;
  assign ex_mem_stall = rst_n & ex_mem_stall_c;
  assign ex_mem_flush = rst_n & ex_mem_flush_c;
  assign mem_wb_flush = rst_n & mem_wb_flush_c;
  assign md_done      = rst_n & md_done_c;

`ifdef HAZ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cyc <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (pc_stall) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      if (if_id_flush | id_ex_flush) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (default build, MD_LAT=4).
// Outputs are packed {pc_stall,if_id_stall,if_id_flush,id_ex_stall,id_ex_flush,ex_mem_stall,ex_mem_flush,mem_wb_flush,md_done}.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ID_rs, ID_rt, EX_wraddr;
  logic       ID_regread1, ID_regread2, ID_jump;
  logic       EX_memread, EX_branch_taken, EX_md_start;
  logic       dmem_req, dmem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_mem_stall, ex_mem_flush, mem_wb_flush, md_done;
  logic [8:0] outs;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] IDLE = 9'b000000000;
  localparam logic [8:0] LU   = 9'b110010000;
  localparam logic [8:0] BR   = 9'b001010000;
  localparam logic [8:0] JMP  = 9'b001000000;
  localparam logic [8:0] MD   = 9'b110100100;
  localparam logic [8:0] DONE = 9'b000000001;
  localparam logic [8:0] MW   = 9'b110101010;

  pipe_hazard_ctrl #(.MD_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .ID_regread1(ID_regread1), .ID_regread2(ID_regread2), .ID_jump(ID_jump),
    .EX_memread(EX_memread), .EX_wraddr(EX_wraddr),
    .EX_branch_taken(EX_branch_taken), .EX_md_start(EX_md_start),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .mem_wb_flush(mem_wb_flush), .md_done(md_done)
  );

  assign outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                 ex_mem_stall, ex_mem_flush, mem_wb_flush, md_done};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Inputs are set just after a falling edge; sample 1 ns later, then move to the next falling edge.
  task automatic cyc(input string tag, input logic [8:0] exp);
    #1;
    check(tag, outs, exp);
    @(negedge clk);
  endtask

  task automatic idle_in();
    ID_rs = 5'd0; ID_rt = 5'd0; EX_wraddr = 5'd0;
    ID_regread1 = 1'b0; ID_regread2 = 1'b0; ID_jump = 1'b0;
    EX_memread = 1'b0; EX_branch_taken = 1'b0; EX_md_start = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    idle_in();
    rst_n = 1'b0;
    EX_md_start = 1'b1;
    EX_branch_taken = 1'b1;
    @(negedge clk);
    cyc("reset_gated", IDLE);
    idle_in();
    rst_n = 1'b1;
    cyc("after_reset", IDLE);

    // load-use on rs, then the load advances
    EX_memread = 1'b1; EX_wraddr = 5'd5; ID_rs = 5'd5; ID_regread1 = 1'b1;
    cyc("lu_rs", LU);
    EX_memread = 1'b0;
    cyc("lu_clear", IDLE);

    // load-use on rt, and an rt match without regread2
    idle_in();
    EX_memread = 1'b1; EX_wraddr = 5'd7; ID_rt = 5'd7; ID_regread2 = 1'b1;
    cyc("lu_rt", LU);
    ID_regread2 = 1'b0;
    cyc("lu_rt_noread", IDLE);

    // $0 destination never stalls
    idle_in();
    EX_memread = 1'b1; EX_wraddr = 5'd0; ID_rs = 5'd0; ID_regread1 = 1'b1;
    cyc("lu_r0", IDLE);

    // branch beats load-use
    EX_wraddr = 5'd9; ID_rs = 5'd9; EX_branch_taken = 1'b1;
    cyc("br_over_lu", BR);
    idle_in();
    ID_jump = 1'b1;
    cyc("jump", JMP);
    EX_branch_taken = 1'b1;
    cyc("br_over_jump", BR);

    // mul/div with start held: 4 freeze cycles, release on the 5th; branch ignored while busy
    idle_in();
    EX_md_start = 1'b1;
    cyc("md_detect", MD);
    cyc("md_busy3", MD);
    EX_branch_taken = 1'b1;
    cyc("md_busy2_br", MD);
    EX_branch_taken = 1'b0;
    cyc("md_busy1", MD);
    cyc("md_done", DONE);
    idle_in();
    cyc("md_after", IDLE);

    // mem wait interrupts mul/div at md_cnt=2
    EX_md_start = 1'b1;
    cyc("mdw_detect", MD);
    cyc("mdw_busy3", MD);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    cyc("mdw_wait1", MW);
    cyc("mdw_wait2", MW);
    cyc("mdw_wait3", MW);
    dmem_ready = 1'b1;
    cyc("mdw_resume2", MD);
    dmem_req = 1'b0; dmem_ready = 1'b0;
    cyc("mdw_resume1", MD);
    cyc("mdw_done", DONE);
    idle_in();
    cyc("mdw_after", IDLE);

    // mem wait from RUN, exit resolves the pending load-use in the same cycle
    dmem_req = 1'b1;
    EX_memread = 1'b1; EX_wraddr = 5'd3; ID_rt = 5'd3; ID_regread2 = 1'b1;
    cyc("mw_over_lu", MW);
    dmem_ready = 1'b1;
    cyc("mw_exit_lu", LU);

    // mem wait beats a new mul/div; the op starts once memory completes
    idle_in();
    dmem_req = 1'b1; EX_md_start = 1'b1;
    cyc("mw_over_md", MW);
    dmem_req = 1'b0;
    cyc("mw_exit_md", MD);
    EX_md_start = 1'b0;
    cyc("md2_busy3", MD);
    cyc("md2_busy2", MD);
    cyc("md2_busy1", MD);
    cyc("md2_done", DONE);

    // reset asserted mid MEM_WAIT with a pending mul/div
    EX_md_start = 1'b1;
    cyc("rst_md_detect", MD);
    dmem_req = 1'b1; dmem_ready = 1'b0;
    cyc("rst_mw", MW);
    #1;
    check("rst_mw_pre", outs, MW);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", outs, IDLE);
    @(negedge clk);
    idle_in();
    rst_n = 1'b1;
    cyc("rst_release", IDLE);
    cyc("rst_no_done", IDLE);
    EX_memread = 1'b1; EX_wraddr = 5'd4; ID_rs = 5'd4; ID_regread1 = 1'b1;
    cyc("rst_then_lu", LU);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
